// File: rtl/adc_frame_stream_unpack.sv
// Unpacks a captured ADC frame (STATUS + NUM_CH channel words) into a sign-extended sample stream.
// Optional channel masking is enabled by defining ADC_UNPACK_CHMASK_EN.
module adc_frame_stream_unpack #(
    parameter int BITS_PER_WORD   = 24,
    parameter int NUM_CH          = 8,
    parameter int WORDS_PER_FRAME = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    input  logic [32*WORDS_PER_FRAME-1:0] frame_words_packed,
    input  logic [NUM_CH-1:0]             ch_mask,
    output logic                          smp_valid,
    input  logic                          smp_ready,
    output logic [31:0]                   smp_data,
    output logic [3:0]                    smp_ch,
    output logic                          smp_last,
    output logic [31:0]                   status_word,
    output logic [15:0]                   frame_cnt,
    output logic [15:0]                   drop_cnt,
    input  logic                          drop_clr
);

    generate
        if (BITS_PER_WORD < 1 || BITS_PER_WORD > 32) begin : g_bad_bits
            $fatal(1, "BITS_PER_WORD must be in 1..32");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
            $fatal(1, "NUM_CH must be in 1..16");
        end
        if (WORDS_PER_FRAME < NUM_CH + 1) begin : g_bad_words
            $fatal(1, "WORDS_PER_FRAME must be at least NUM_CH+1");
        end
    endgenerate

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state_reg;
    logic [NUM_CH-1:0]        mask_reg;
    logic [BITS_PER_WORD-1:0] ch_word_reg [NUM_CH];
    logic [BITS_PER_WORD-1:0] in_word     [NUM_CH];
    logic [NUM_CH-1:0]        in_mask;
    logic                     unused_ok;

    // Word 0 is STATUS, so channel gi lives in word gi+1.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign in_word[gi] = frame_words_packed[32*(gi+1) +: BITS_PER_WORD];
        end
    endgenerate

`ifdef ADC_UNPACK_CHMASK_EN
    assign in_mask   = ch_mask;
    assign unused_ok = ^frame_words_packed;
`else
    assign in_mask   = '1;
    assign unused_ok = ^{frame_words_packed, ch_mask};
`endif

    function automatic logic [31:0] sext(input logic [BITS_PER_WORD-1:0] w);
        return 32'($signed(w));
    endfunction

    logic        accept;
    logic        handshake;
    logic        first_found;
    logic [3:0]  first_idx;
    logic [31:0] first_data;
    logic        first_last;
    logic [3:0]  nxt_idx;
    logic [31:0] nxt_data;
    logic        nxt_last;

    assign handshake = smp_valid && smp_ready;
    assign accept    = frame_valid && (state_reg == IDLE || (handshake && smp_last));

    // Lowest enabled channel of the incoming frame, and of the held frame above smp_ch.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        first_data  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_mask[i]) begin
                first_found = 1'b1;
                first_idx   = 4'(i);
                first_data  = sext(in_word[i]);
            end
        end
        first_last = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_mask[i] && i > int'(first_idx)) first_last = 1'b0;
        end

        nxt_idx  = smp_ch;
        nxt_data = smp_data;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_reg[i] && i > int'(smp_ch)) begin
                nxt_idx  = 4'(i);
                nxt_data = sext(ch_word_reg[i]);
            end
        end
        nxt_last = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_reg[i] && i > int'(nxt_idx)) nxt_last = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            smp_valid   <= 1'b0;
            smp_data    <= '0;
            smp_ch      <= '0;
            smp_last    <= 1'b0;
            status_word <= '0;
            frame_cnt   <= '0;
            mask_reg    <= '0;
        end else if (accept) begin
            status_word <= frame_words_packed[31:0];
            frame_cnt   <= frame_cnt + 16'd1;
            mask_reg    <= in_mask;
            if (first_found) begin
                state_reg <= EMIT;
                smp_valid <= 1'b1;
                smp_data  <= first_data;
                smp_ch    <= first_idx;
                smp_last  <= first_last;
            end else begin
                state_reg <= IDLE;
                smp_valid <= 1'b0;
            end
        end else if (handshake) begin
            if (smp_last) begin
                state_reg <= IDLE;
                smp_valid <= 1'b0;
            end else begin
                smp_data <= nxt_data;
                smp_ch   <= nxt_idx;
                smp_last <= nxt_last;
            end
        end
    end

    // Channel payload needs no reset: it is only observed after an accept reloads it.
    always_ff @(posedge clk) begin
        if (accept) ch_word_reg <= in_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (frame_valid && !accept && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_frame_stream_unpack.sv
// Self-checking bench for adc_frame_stream_unpack: queue-based sample model plus directed literal checks.
module tb_adc_frame_stream_unpack;
    localparam int B = 24;
    localparam int N = 8;
    localparam int W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_valid = 1'b0;
    logic [32*W-1:0]  frame_words_packed = '0;
    logic [N-1:0]     ch_mask = '1;
    logic             smp_valid;
    logic             smp_ready = 1'b0;
    logic [31:0]      smp_data;
    logic [3:0]       smp_ch;
    logic             smp_last;
    logic [31:0]      status_word;
    logic [15:0]      frame_cnt;
    logic [15:0]      drop_cnt;
    logic             drop_clr = 1'b0;

    adc_frame_stream_unpack #(
        .BITS_PER_WORD(B), .NUM_CH(N), .WORDS_PER_FRAME(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
        .frame_words_packed(frame_words_packed), .ch_mask(ch_mask),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .smp_ch(smp_ch), .smp_last(smp_last), .status_word(status_word),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: a frame becomes a list of expected samples; the DUT must drain it in order.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  ch;
        logic        last;
    } smp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  ch;
        logic        last;
        int          cyc;
    } log_t;

    smp_t        exp_q[$];
    log_t        log_q[$];
    logic [15:0] m_frame  = '0;
    logic [15:0] m_drop   = '0;
    logic [31:0] m_status = '0;
    int          cyc      = 0;

    function automatic logic [31:0] sext_model(input logic [31:0] w);
        longint v;
        v = longint'(w) & ((longint'(1) << B) - 1);
        if (v >= (longint'(1) << (B - 1))) v = v - (longint'(1) << B);
        return 32'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit   acc;
        int   sz;
        smp_t s;
        logic [N-1:0] m;
        if (!rst_n) begin
            exp_q.delete();
            m_frame  = '0;
            m_drop   = '0;
            m_status = '0;
        end else begin
            sz  = exp_q.size();
            acc = frame_valid && (sz == 0 || (sz == 1 && smp_ready));
            if (sz > 0 && smp_ready) void'(exp_q.pop_front());
            if (drop_clr) m_drop = '0;
            else if (frame_valid && !acc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            if (acc) begin
                m_status = frame_words_packed[31:0];
                m_frame  = m_frame + 16'd1;
`ifdef ADC_UNPACK_CHMASK_EN
                m = ch_mask;
`else
                m = '1;
`endif
                for (int c = 0; c < N; c++) begin
                    if (m[c]) begin
                        s.data = sext_model(frame_words_packed[32*(c+1) +: 32]);
                        s.ch   = 4'(c);
                        s.last = 1'b0;
                        exp_q.push_back(s);
                    end
                end
                if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        log_t l;
        cyc++;
        chk("smp_valid", 32'(smp_valid), 32'(exp_q.size() != 0));
        if (smp_valid && exp_q.size() != 0) begin
            chk("smp_data", smp_data, exp_q[0].data);
            chk("smp_ch", 32'(smp_ch), 32'(exp_q[0].ch));
            chk("smp_last", 32'(smp_last), 32'(exp_q[0].last));
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("status_word", status_word, m_status);
        if (smp_valid && smp_ready) begin
            l.data = smp_data;
            l.ch   = smp_ch;
            l.last = smp_last;
            l.cyc  = cyc;
            log_q.push_back(l);
            $display("sample ch=%0d data=0x%08h last=%0b cyc=%0d", smp_ch, smp_data, smp_last, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input logic [31:0] st, input logic [31:0] seed);
        frame_words_packed = '0;
        frame_words_packed[31:0] = st;
        for (int k = 0; k < N; k++)
            frame_words_packed[32*(k+1) +: 32] = 32'h5A5A5A5A ^ (seed + 32'(k) * 32'h00923457);
        frame_words_packed[32*(W-1) +: 32] = 32'hDEADBEEF;
    endtask

    task automatic pulse_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(smp_valid), 32'd0);
        chk({tag, "_data"}, smp_data, 32'd0);
        chk({tag, "_ch"}, 32'(smp_ch), 32'd0);
        chk({tag, "_last"}, 32'(smp_last), 32'd0);
        chk({tag, "_status"}, status_word, 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame, ready always high.
        smp_ready = 1'b1;
        log_q.delete();
        build_frame(32'hA5A50001, 32'h11);
        frame_words_packed[32*1 +: 32] = 32'h00800000;
        frame_words_packed[32*2 +: 32] = 32'h007FFFFF;
        pulse_frame();
        repeat (12) tick();
        chk("a_count", 32'(log_q.size()), 32'd8);
        chk("a_data0", log_q[0].data, 32'hFF800000);
        chk("a_data1", log_q[1].data, 32'h007FFFFF);
        chk("a_last_ch", 32'(log_q[7].ch), 32'd7);
        chk("a_last_flag", 32'(log_q[7].last), 32'd1);
        chk("a_span", 32'(log_q[7].cyc - log_q[0].cyc), 32'd7);
        chk("a_frame_cnt", 32'(frame_cnt), 32'd1);

        // Ready toggling every cycle.
        log_q.delete();
        build_frame(32'hB0B00002, 32'h2222);
        pulse_frame();
        for (int i = 0; i < 20; i++) begin
            smp_ready = (i % 2 == 0);
            tick();
        end
        smp_ready = 1'b1;
        chk("b_count", 32'(log_q.size()), 32'd8);
        chk("b_span", 32'(log_q[7].cyc - log_q[0].cyc), 32'd14);

        // Drop mid-frame, then back-to-back accept on the last handshake.
        log_q.delete();
        build_frame(32'hC0C00003, 32'h333333);
        pulse_frame();
        tick();
        tick();
        pulse_frame();
        chk("c_drop", 32'(drop_cnt), 32'd1);
        for (k = 0; k < 20 && !(smp_valid && smp_last); k++) tick();
        chk("c_wait_last", 32'(smp_valid && smp_last), 32'd1);
        build_frame(32'hC0C00004, 32'h44444444);
        pulse_frame();
        chk("c_drop_kept", 32'(drop_cnt), 32'd1);
        chk("c_no_gap_valid", 32'(smp_valid), 32'd1);
        chk("c_no_gap_ch", 32'(smp_ch), 32'd0);
        chk("c_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("c_first_count", 32'(log_q.size()), 32'd8);
        repeat (12) tick();

        // Drop counter saturation and clear priority.
        smp_ready = 1'b0;
        build_frame(32'hD0D00005, 32'h55);
        frame_valid = 1'b1;
        tick();
        drop_clr = 1'b1;
        tick();
        chk("d_clr", 32'(drop_cnt), 32'd0);
        drop_clr = 1'b0;
        repeat (65535) tick();
        chk("d_full", 32'(drop_cnt), 32'h0000FFFF);
        tick();
        chk("d_sat", 32'(drop_cnt), 32'h0000FFFF);
        drop_clr = 1'b1;
        tick();
        chk("d_clr_prio", 32'(drop_cnt), 32'd0);
        drop_clr    = 1'b0;
        frame_valid = 1'b0;
        smp_ready   = 1'b1;
        repeat (12) tick();

        // Reset in the middle of a frame.
        build_frame(32'hE0E00006, 32'h66);
        pulse_frame();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("e_idle", 32'(smp_valid), 32'd0);

        // Channel mask 0x05, then all-zero mask.
        log_q.delete();
        ch_mask = 8'h05;
        build_frame(32'hF0F00007, 32'h77);
        pulse_frame();
        repeat (12) tick();
`ifdef ADC_UNPACK_CHMASK_EN
        chk("f_count", 32'(log_q.size()), 32'd2);
        chk("f_ch0", 32'(log_q[0].ch), 32'd0);
        chk("f_ch1", 32'(log_q[1].ch), 32'd2);
        chk("f_last", 32'(log_q[1].last), 32'd1);
`else
        chk("f_count", 32'(log_q.size()), 32'd8);
        chk("f_ch2", 32'(log_q[2].ch), 32'd2);
        chk("f_last", 32'(log_q[7].last), 32'd1);
`endif
        log_q.delete();
        ch_mask = 8'h00;
        build_frame(32'hF0F00008, 32'h88);
        pulse_frame();
        chk("g_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("g_status", status_word, 32'hF0F00008);
        repeat (12) tick();
`ifdef ADC_UNPACK_CHMASK_EN
        chk("g_count", 32'(log_q.size()), 32'd0);
`else
        chk("g_count", 32'(log_q.size()), 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_frame_stream_unpack.md
ADC_FRAME_STREAM_UNPACK -- requirements
Module: adc_frame_stream_unpack

Interface
REQ-001 SHALL have parameter BITS_PER_WORD, default 24: valid low bits per captured word, legal range 1..32.
REQ-002 SHALL have parameter NUM_CH, default 8: channel words after STATUS, legal range 1..16.
REQ-003 SHALL have parameter WORDS_PER_FRAME, default 10: words in the packed frame, legal minimum NUM_CH+1.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_valid  in  1  one-cycle pulse; a captured frame is present this cycle; cannot be stalled.
REQ-007 frame_words_packed  in  32*WORDS_PER_FRAME  word k in bits [32k+31:32k]; word0 = STATUS, words 1..NUM_CH = CH0..CH(NUM_CH-1); trailing words are ignored.
REQ-008 ch_mask  in  NUM_CH  per-channel emit enable; used only under REQ-030.
REQ-009 smp_valid / smp_ready  out / in  1 / 1  sample stream handshake.
REQ-010 smp_data  out  32  sign-extended channel sample.
REQ-011 smp_ch  out  4  channel index of smp_data.
REQ-012 smp_last  out  1  high on the final sample of a frame.
REQ-013 status_word  out  32  STATUS word of the most recently accepted frame, unmodified.
REQ-014 frame_cnt  out  16  count of accepted frames.
REQ-015 drop_cnt / drop_clr  out / in  16 / 1  dropped-frame counter and its synchronous clear.

Function
REQ-016 SHALL halt elaboration with $fatal on any parameter outside its legal range.
REQ-017 SHALL implement a two-state FSM: IDLE (no frame held) and EMIT (presenting samples).
REQ-018 SHALL accept a frame on a frame_valid pulse when in IDLE, or in EMIT in the same cycle the last sample handshakes (smp_valid & smp_ready & smp_last).
REQ-019 SHALL, on accept, latch all NUM_CH channel words and ch_mask, load status_word, increment frame_cnt (wrapping 0xFFFF->0), and present the first sample in the next cycle (latency 1).
REQ-020 SHALL, on a frame_valid pulse that is not accepted, discard the frame and increment drop_cnt, saturating at 0xFFFF.
REQ-021 drop_clr SHALL zero drop_cnt in the next cycle and SHALL take priority over a simultaneous drop.
REQ-022 SHALL emit samples in ascending channel order, advancing only on smp_valid & smp_ready, while holding smp_data, smp_ch and smp_last stable while smp_valid & !smp_ready.
REQ-023 smp_data SHALL be word[BITS_PER_WORD-1:0] sign-extended from bit BITS_PER_WORD-1 to 32 bits, passed through unchanged when BITS_PER_WORD = 32.
REQ-024 SHALL return to IDLE after the last handshake unless a new frame is accepted in the same cycle, in which case smp_valid stays high with the new frame's first sample.
REQ-025 SHALL leave smp_valid low whenever in IDLE.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force: FSM=IDLE, smp_valid=0, smp_data=0, smp_ch=0, smp_last=0, status_word=0, frame_cnt=0, drop_cnt=0.
REQ-027 Reset asserted mid-frame SHALL abandon the held frame; no sample from it appears after reset release.
REQ-028 SHALL ignore frame_valid in the cycle rst_n deasserts only if it is sampled while rst_n is low; the first rising edge with rst_n high is fully functional.

Configuration
REQ-029 Macro ADC_UNPACK_CHMASK_EN SHALL control channel masking.
REQ-030 Macro ADC_UNPACK_CHMASK_EN defined: emit only channels whose latched ch_mask bit is 1; smp_last marks the highest enabled channel; an all-zero mask still accepts the frame (updating status_word and frame_cnt), emits nothing, and leaves the FSM in IDLE.
REQ-031 Macro ADC_UNPACK_CHMASK_EN undefined: ch_mask is ignored; all NUM_CH channels are emitted and smp_last marks channel NUM_CH-1.

Verification
REQ-032 Defaults, smp_ready=1, one frame with CH0=0x00800000, CH1=0x007FFFFF -> smp_data 0xFF800000 then 0x007FFFFF; 8 samples on consecutive cycles; smp_last on smp_ch=7; frame_cnt=1.
REQ-033 smp_ready toggling 1/0 every cycle -> each sample held stable while stalled; 8 samples delivered in 15 cycles with no loss or duplication.
REQ-034 Second frame_valid pulse 3 cycles into EMIT -> drop_cnt=1 and the first frame completes intact; a pulse coincident with the last handshake -> accepted, drop_cnt unchanged, no idle gap.
REQ-035 drop_cnt preset to 0xFFFF plus a further drop -> drop_cnt stays 0xFFFF; drop_clr coincident with a drop -> drop_cnt=0.
REQ-036 With ADC_UNPACK_CHMASK_EN defined and ch_mask=0x05 -> only channels 0 and 2 are emitted, smp_last on channel 2; with ch_mask=0x00 -> frame_cnt increments and no smp_valid; rst_n pulsed mid-EMIT -> all outputs 0 and FSM in IDLE.
